// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Central stall/flush control for the rv32i pipeline. Keeps a shadow of each
//   in-flight instruction (valid, rd, we, is_load) and produces per-stage
//   load-enable and flush strobes for memory freezes, load-use bubbles and
//   branch redirects.
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   imem_read/imem_resp             instruction port handshake
//   dmem_req/dmem_resp              data port handshake
//   dec_*                           instruction currently in decode
//   redirect                        taken branch/jump from REDIRECT_STAGE
//   stage_en, flush                 per-stage register load / bubble strobes
//   valid                           registered shadow valid bits
//   frozen, load_use                current-cycle condition flags
//   freeze_cycles, bubble_cycles    wrapping performance counters
module pipeline_ctrl #(
  parameter int STAGES            = 5,
  parameter int REDIRECT_STAGE    = 3,
  parameter int LOAD_RESULT_STAGE = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imem_read,
  input  logic              imem_resp,
  input  logic              dmem_req,
  input  logic              dmem_resp,
  input  logic              dec_valid,
  input  logic [4:0]        dec_rd,
  input  logic              dec_we,
  input  logic              dec_is_load,
  input  logic [4:0]        dec_rs1,
  input  logic [4:0]        dec_rs2,
  input  logic              dec_use_rs1,
  input  logic              dec_use_rs2,
  input  logic              redirect,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] flush,
  output logic [STAGES-1:0] valid,
  output logic              frozen,
  output logic              load_use,
  output logic [31:0]       freeze_cycles,
  output logic [31:0]       bubble_cycles
);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [4:0]        rd_q [2:STAGES-1];
  logic [4:0]        rd_d [2:STAGES-1];
  logic [STAGES-1:2] we_q, we_d;
  logic [STAGES-1:2] ld_q, ld_d;
  logic [31:0]       freeze_cycles_q, freeze_cycles_d;
  logic [31:0]       bubble_cycles_q, bubble_cycles_d;

  logic              mem_stall_s;
  logic              hazard_s;
  logic              load_use_s;
  logic              frozen_s;
  logic [STAGES-1:0] stage_en_s;
  logic [STAGES-1:0] flush_s;

  assign mem_stall_s = (imem_read & ~imem_resp) | (dmem_req & ~dmem_resp);

  // Load-use hazard: a load still short of the result stage feeds a used source.
  always_comb begin
    hazard_s = 1'b0;
    for (int s = 2; s < LOAD_RESULT_STAGE; s++) begin
      if (valid_q[s] && ld_q[s] && we_q[s] && (rd_q[s] != 5'd0) &&
          ((dec_use_rs1 && (dec_rs1 == rd_q[s])) ||
           (dec_use_rs2 && (dec_rs2 == rd_q[s])))) begin
        hazard_s = 1'b1;
      end else begin
        hazard_s = hazard_s;
      end
    end
  end

  // Prioritised stage enable / flush decision: reset, freeze, redirect, load-use.
  always_comb begin
    stage_en_s = '1;
    flush_s    = '0;
    frozen_s   = 1'b0;
    load_use_s = 1'b0;
    if (reset) begin
      flush_s = '1;
    end else if (mem_stall_s) begin
      stage_en_s = '0;
      frozen_s   = 1'b1;
    end else if (redirect) begin
      // Squash everything younger than the branch; fetch loads the new PC.
      for (int i = 1; i <= REDIRECT_STAGE; i++) begin
        flush_s[i] = 1'b1;
      end
    end else if (dec_valid && hazard_s) begin
      load_use_s    = 1'b1;
      stage_en_s[0] = 1'b0;
      stage_en_s[1] = 1'b0;
      flush_s[2]    = 1'b1;
    end else begin
      stage_en_s = '1;
    end
  end

  // Shadow and counter next-state; a freeze holds everything but its counter.
  always_comb begin
    valid_d         = valid_q;
    rd_d            = rd_q;
    we_d            = we_q;
    ld_d            = ld_q;
    freeze_cycles_d = freeze_cycles_q;
    bubble_cycles_d = bubble_cycles_q;
    valid_d[0]      = 1'b1;
    if (mem_stall_s) begin
      freeze_cycles_d = freeze_cycles_q + 32'd1;
    end else begin
      valid_d[1] = stage_en_s[1] ? (valid_q[0] & ~flush_s[1]) : valid_q[1];
      valid_d[2] = dec_valid & ~flush_s[2];
      rd_d[2]    = dec_rd;
      // A write to x0 is never a real producer.
      we_d[2]    = dec_we & (dec_rd != 5'd0);
      ld_d[2]    = dec_is_load;
      for (int i = 3; i < STAGES; i++) begin
        valid_d[i] = valid_q[i-1] & ~flush_s[i];
        rd_d[i]    = rd_q[i-1];
        we_d[i]    = we_q[i-1];
        ld_d[i]    = ld_q[i-1];
      end
      if (redirect || load_use_s) begin
        bubble_cycles_d = bubble_cycles_q + 32'd1;
      end else begin
        bubble_cycles_d = bubble_cycles_q;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q         <= '0;
      freeze_cycles_q <= 32'd0;
      bubble_cycles_q <= 32'd0;
    end else begin
      valid_q         <= valid_d;
      freeze_cycles_q <= freeze_cycles_d;
      bubble_cycles_q <= bubble_cycles_d;
    end
    rd_q <= rd_d;
    we_q <= we_d;
    ld_q <= ld_d;
  end

  assign stage_en      = stage_en_s;
  assign flush         = flush_s;
  assign frozen        = frozen_s;
  assign load_use      = load_use_s;
  assign valid         = valid_q;
  assign freeze_cycles = freeze_cycles_q;
  assign bubble_cycles = bubble_cycles_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: directed scenarios plus randomized traffic checked
// against an instruction-level reference model. A second instance with
// STAGES=6 / LOAD_RESULT_STAGE=4 shares the inputs for the two-bubble case.
module tb_pipeline_ctrl;
  localparam int S = 5;
  localparam int R = 3;
  localparam int L = 3;

  logic clk = 1'b0;
  logic reset;
  logic imem_read, imem_resp, dmem_req, dmem_resp;
  logic dec_valid, dec_we, dec_is_load, dec_use_rs1, dec_use_rs2, redirect;
  logic [4:0] dec_rd, dec_rs1, dec_rs2;

  logic [S-1:0] stage_en, flush, valid;
  logic frozen, load_use;
  logic [31:0] freeze_cycles, bubble_cycles;

  logic [5:0] stage_en6, flush6, valid6;
  logic frozen6, load_use6;
  logic [31:0] freeze_cycles6, bubble_cycles6;

  int checks = 0;
  int failures = 0;

  // Reference model: one record per pipeline position 2..S-1.
  bit        mv  [0:7];
  bit [4:0]  mrd [0:7];
  bit        mwe [0:7];
  bit        mld [0:7];
  bit        mv0, mv1;
  int unsigned mfreeze, mbubble;

  always #5 clk = ~clk;

  pipeline_ctrl #(.STAGES(S), .REDIRECT_STAGE(R), .LOAD_RESULT_STAGE(L)) dut (
    .clk(clk), .reset(reset), .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .dec_valid(dec_valid),
    .dec_rd(dec_rd), .dec_we(dec_we), .dec_is_load(dec_is_load),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1),
    .dec_use_rs2(dec_use_rs2), .redirect(redirect), .stage_en(stage_en),
    .flush(flush), .valid(valid), .frozen(frozen), .load_use(load_use),
    .freeze_cycles(freeze_cycles), .bubble_cycles(bubble_cycles));

  pipeline_ctrl #(.STAGES(6), .REDIRECT_STAGE(3), .LOAD_RESULT_STAGE(4)) dut6 (
    .clk(clk), .reset(reset), .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp), .dec_valid(dec_valid),
    .dec_rd(dec_rd), .dec_we(dec_we), .dec_is_load(dec_is_load),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_use_rs1(dec_use_rs1),
    .dec_use_rs2(dec_use_rs2), .redirect(redirect), .stage_en(stage_en6),
    .flush(flush6), .valid(valid6), .frozen(frozen6), .load_use(load_use6),
    .freeze_cycles(freeze_cycles6), .bubble_cycles(bubble_cycles6));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic idle();
    imem_read = 1'b0; imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b1;
    dec_valid = 1'b0; dec_rd = 5'd0; dec_we = 1'b0; dec_is_load = 1'b0;
    dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_use_rs1 = 1'b0; dec_use_rs2 = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic set_dec(input bit v, input bit [4:0] rd, input bit we, input bit ld,
                         input bit [4:0] rs1, input bit u1, input bit [4:0] rs2, input bit u2);
    dec_valid = v; dec_rd = rd; dec_we = we; dec_is_load = ld;
    dec_rs1 = rs1; dec_use_rs1 = u1; dec_rs2 = rs2; dec_use_rs2 = u2;
  endtask

  // Check the main instance against the model, then step one clock.
  task automatic cycle();
    bit frz, haz, lu;
    logic [S-1:0] e_en, e_fl, e_valid;
    #1;
    frz = (imem_read && !imem_resp) || (dmem_req && !dmem_resp);
    haz = 1'b0;
    for (int s = 2; s < L; s++)
      if (mv[s] && mld[s] && mwe[s] && mrd[s] != 5'd0 &&
          ((dec_use_rs1 && dec_rs1 == mrd[s]) || (dec_use_rs2 && dec_rs2 == mrd[s])))
        haz = 1'b1;
    lu = !reset && !frz && !redirect && dec_valid && haz;
    e_en = '1; e_fl = '0;
    if (reset) e_fl = '1;
    else if (frz) e_en = '0;
    else if (redirect) for (int i = 1; i <= R; i++) e_fl[i] = 1'b1;
    else if (lu) begin e_en[1:0] = 2'b00; e_fl[2] = 1'b1; end
    e_valid[0] = mv0; e_valid[1] = mv1;
    for (int i = 2; i < S; i++) e_valid[i] = mv[i];
    chk("stage_en", stage_en, e_en);
    chk("flush", flush, e_fl);
    chk("frozen", frozen, !reset && frz);
    chk("load_use", load_use, lu);
    chk("valid", valid, e_valid);
    chk("freeze_cycles", freeze_cycles, mfreeze);
    chk("bubble_cycles", bubble_cycles, mbubble);
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 8; i++) mv[i] = 1'b0;
      mv0 = 1'b0; mv1 = 1'b0; mfreeze = 0; mbubble = 0;
    end else if (frz) begin
      mfreeze++;
      mv0 = 1'b1;
    end else begin
      for (int i = S - 1; i >= 3; i--) begin
        mv[i] = mv[i-1] && !(redirect && i <= R);
        mrd[i] = mrd[i-1]; mwe[i] = mwe[i-1]; mld[i] = mld[i-1];
      end
      mv[2] = dec_valid && !redirect && !lu;
      mrd[2] = dec_rd; mwe[2] = dec_we && (dec_rd != 5'd0); mld[2] = dec_is_load;
      if (redirect) mv1 = 1'b0;
      else if (!lu) mv1 = mv0;
      mv0 = 1'b1;
      if (redirect || lu) mbubble++;
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    reset = 1'b1;
    @(negedge clk);
    repeat (2) begin
      #1;
      chk("rst_stage_en", stage_en, 5'h1f);
      chk("rst_flush", flush, 5'h1f);
      chk("rst_stage_en6", stage_en6, 6'h3f);
      cycle();
    end
    reset = 1'b0;
    #1;
    chk("rel_valid", valid[4:1], 4'h0);
    chk("rel_freeze", freeze_cycles, 32'd0);
    chk("rel_bubble", bubble_cycles, 32'd0);
    repeat (2) cycle();

    // Load x5 followed by a reader of x5.
    set_dec(1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    cycle();
    set_dec(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    chk("lu_first", load_use, 1'b1);
    chk("lu_stage_en", stage_en, 5'b11100);
    chk("lu_flush2", flush[2], 1'b1);
    chk("lu6_first", load_use6, 1'b1);
    cycle();
    #1;
    chk("lu_done", load_use, 1'b0);
    chk("lu_bubble", bubble_cycles, 32'd1);
    chk("lu6_second", load_use6, 1'b1);
    chk("lu6_stage_en", stage_en6, 6'b111100);
    cycle();
    #1;
    chk("lu6_done", load_use6, 1'b0);
    chk("lu6_bubble", bubble_cycles6, 32'd2);
    cycle();
    idle();
    repeat (3) cycle();

    // Load into x0 then a reader of x0: never a hazard.
    set_dec(1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    cycle();
    set_dec(1'b1, 5'd9, 1'b1, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1);
    #1;
    chk("x0_no_lu", load_use, 1'b0);
    cycle();
    idle();
    repeat (3) cycle();

    // Data-port freeze for four cycles.
    set_dec(1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    cycle();
    dmem_req = 1'b1; dmem_resp = 1'b0;
    repeat (4) begin
      #1;
      chk("frz_frozen", frozen, 1'b1);
      chk("frz_stage_en", stage_en, 5'b00000);
      cycle();
    end
    dmem_resp = 1'b1;
    #1;
    chk("frz_count", freeze_cycles, 32'd4);
    chk("frz_released", frozen, 1'b0);
    cycle();
    idle();
    repeat (3) cycle();

    // Redirect overrides a simultaneous load-use.
    set_dec(1'b1, 5'd5, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    cycle();
    set_dec(1'b1, 5'd6, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
    redirect = 1'b1;
    #1;
    chk("rd_stage_en", stage_en, 5'b11111);
    chk("rd_flush", flush, 5'b01110);
    chk("rd_no_lu", load_use, 1'b0);
    cycle();
    idle();
    #1;
    chk("rd_bubble", bubble_cycles, 32'd2);
    cycle();

    // Randomized traffic, including resets in the middle of stalls.
    for (int n = 0; n < 3000; n++) begin
      reset       = ($urandom_range(0, 99) == 0);
      imem_read   = $urandom_range(0, 1);
      imem_resp   = ($urandom_range(0, 4) != 0);
      dmem_req    = $urandom_range(0, 1);
      dmem_resp   = ($urandom_range(0, 4) != 0);
      dec_valid   = ($urandom_range(0, 3) != 0);
      dec_rd      = 5'($urandom_range(0, 3));
      dec_we      = $urandom_range(0, 1);
      dec_is_load = $urandom_range(0, 1);
      dec_rs1     = 5'($urandom_range(0, 3));
      dec_rs2     = 5'($urandom_range(0, 3));
      dec_use_rs1 = $urandom_range(0, 1);
      dec_use_rs2 = $urandom_range(0, 1);
      redirect    = ($urandom_range(0, 9) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
